// File: rtl/scds_pkg.sv
// scds_pkg: shared constants, rotation encoding and saturating negate for scds_gen.
// Latency: n/a (package).
// Backpressure: n/a (package).
package scds_pkg;

  // Default LFSR load value; bit i holds s[i]
  localparam logic [12:0] SEED_DEF = 13'h1FFF;

  // Feedback taps: fb1 = s7^s10^s11^s12, fb2 = s6^s9^s10^s11
  localparam int FB1_T0 = 7;
  localparam int FB1_T1 = 10;
  localparam int FB1_T2 = 11;
  localparam int FB1_T3 = 12;
  localparam int FB2_T0 = 6;
  localparam int FB2_T1 = 9;
  localparam int FB2_T2 = 10;
  localparam int FB2_T3 = 11;

  // Rotation applied to (re, im); the value equals the descramble-mode sel {s0, s1}
  typedef enum logic [1:0] {
    ROT_ID  = 2'b00,  // (re, im)
    ROT_NEG = 2'b01,  // (-re, -im)
    ROT_NJ  = 2'b10,  // x(-j): (im, -re)
    ROT_PJ  = 2'b11   // x(+j): (-im, re)
  } rot_e;

  // Two's complement negate of a w-bit value (sign-extended into x); the most
  // negative code maps to the most positive one instead of overflowing
  function automatic logic signed [31:0] sat_neg(input logic signed [31:0] x, input int w);
    logic signed [31:0] lo;
    lo = -(32'sd1 <<< (w - 1));
    if (x == lo) return (32'sd1 <<< (w - 1)) - 32'sd1;
    return -x;
  endfunction

endpackage

// File: rtl/scds_lfsr.sv
// scds_lfsr: 13-bit dual-output LFSR producing the 2-bit rotation select {s0, s1}.
// Latency: sel reflects the current state; load/adv take effect on the next clock.
// Backpressure: none; the caller only asserts load/adv on accepted samples.
module scds_lfsr
  import scds_pkg::*;
#(
  parameter logic [12:0] SEED = SEED_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       adv,
  output logic [1:0] sel
);

  logic [12:0] s_q, s_d;
  logic        fb1, fb2;

  // Next state: reload wins over advance; advance shifts two new bits in at s0/s1
  always_comb begin
    fb1 = s_q[FB1_T0] ^ s_q[FB1_T1] ^ s_q[FB1_T2] ^ s_q[FB1_T3];
    fb2 = s_q[FB2_T0] ^ s_q[FB2_T1] ^ s_q[FB2_T2] ^ s_q[FB2_T3];
    s_d = s_q;
    if (load)     s_d = SEED;
    else if (adv) s_d = {s_q[10:0], fb1, fb2};
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) s_q <= SEED;
    else     s_q <= s_d;
  end

  assign sel = {s_q[0], s_q[1]};

endmodule

// File: rtl/scds_gen.sv
// scds_gen: quarter-turn constellation scrambler/descrambler over an in-frame index window.
// Latency: one register stage; a sample accepted in cycle n is presented in cycle n+1.
// Backpressure: di_rdy = !do_vld || do_rdy; all do_* hold while do_vld && !do_rdy.
module scds_gen
  import scds_pkg::*;
#(
  parameter int          DW        = 12,
  parameter int          IW        = 10,
  parameter int          WIN_START = 16,
  parameter int          WIN_END   = 494,
  parameter logic [12:0] SEED      = SEED_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic signed [DW-1:0] di_re,
  input  logic signed [DW-1:0] di_im,
  input  logic                 di_sop,
  input  logic                 di_vld,
  output logic                 di_rdy,
  output logic signed [DW-1:0] do_re,
  output logic signed [DW-1:0] do_im,
  output logic                 do_sop,
  output logic                 do_win,
  output logic                 do_vld,
  input  logic                 do_rdy
);

  localparam logic [IW-1:0] IDX_MAX  = '1;
  // A sop sample always sees the seed selection, whatever state the LFSR is in
  localparam logic [1:0]    SEED_SEL = {SEED[0], SEED[1]};

  logic                 acc;
  logic [IW-1:0]        idx_q, idx_d, cur_idx;
  logic                 mode_q, mode_d, eff_mode;
  logic                 in_win;
  logic [1:0]           lfsr_sel, sel;
  logic                 lfsr_load, lfsr_adv;
  rot_e                 rot;
  logic signed [DW-1:0] neg_re, neg_im, rot_re, rot_im;
  logic signed [DW-1:0] do_re_q, do_im_q;
  logic                 do_sop_q, do_win_q, do_vld_q;

  assign di_rdy = !do_vld_q || do_rdy;
  assign acc    = di_vld && di_rdy;

  scds_lfsr #(.SEED(SEED)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .adv  (lfsr_adv),
    .sel  (lfsr_sel)
  );

  // Index, window, mode and LFSR control for the sample currently offered
  always_comb begin
    cur_idx  = di_sop ? '0 : idx_q;
    in_win   = (int'(cur_idx) >= WIN_START) && (int'(cur_idx) <= WIN_END);
    eff_mode = di_sop ? mode : mode_q;
    idx_d    = idx_q;
    mode_d   = mode_q;
    if (acc) begin
      if (di_sop) begin
        idx_d  = IW'(1);
        mode_d = mode;
      end else if (idx_q != IDX_MAX) begin
        idx_d  = idx_q + IW'(1);
      end
    end
    // Out-of-window samples and frame starts park the LFSR at the seed
    lfsr_load = acc && (di_sop || !in_win);
    lfsr_adv  = acc && in_win;
    sel       = di_sop ? SEED_SEL : lfsr_sel;
  end

  // Rotation select and datapath; scramble swaps the +j/-j rows to invert descramble
  always_comb begin
    rot = rot_e'(sel);
    if (eff_mode) begin
      if (rot == ROT_NJ)      rot = ROT_PJ;
      else if (rot == ROT_PJ) rot = ROT_NJ;
    end
    neg_re = DW'(sat_neg(32'(di_re), DW));
    neg_im = DW'(sat_neg(32'(di_im), DW));
    rot_re = di_re;
    rot_im = di_im;
    if (in_win) begin
      case (rot)
        ROT_NJ:  begin rot_re = di_im;  rot_im = neg_re; end
        ROT_NEG: begin rot_re = neg_re; rot_im = neg_im; end
        ROT_PJ:  begin rot_re = neg_im; rot_im = di_re;  end
        default: begin rot_re = di_re;  rot_im = di_im;  end
      endcase
    end
  end

  // Frame index counter and latched mode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      mode_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      mode_q <= mode_d;
    end
  end

  // Output register: load on accept, drop valid once consumed, hold while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      do_re_q  <= '0;
      do_im_q  <= '0;
      do_sop_q <= 1'b0;
      do_win_q <= 1'b0;
      do_vld_q <= 1'b0;
    end else if (acc) begin
      do_re_q  <= rot_re;
      do_im_q  <= rot_im;
      do_sop_q <= di_sop;
      do_win_q <= in_win;
      do_vld_q <= 1'b1;
    end else if (do_rdy) begin
      do_vld_q <= 1'b0;
    end
  end

  assign do_re  = do_re_q;
  assign do_im  = do_im_q;
  assign do_sop = do_sop_q;
  assign do_win = do_win_q;
  assign do_vld = do_vld_q;

endmodule

// File: tb/tb_scds_gen.sv
module tb_scds_gen;
  localparam int DW = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mode, di_sop, di_vld, do_rdy;
  logic signed [DW-1:0] di_re, di_im;

  logic a_di_rdy, a_do_sop, a_do_win, a_do_vld;
  logic signed [DW-1:0] a_do_re, a_do_im;
  logic w_di_rdy, w_do_sop, w_do_win, w_do_vld;
  logic signed [DW-1:0] w_do_re, w_do_im;
  logic s_di_rdy, s_do_sop, s_do_win, s_do_vld;
  logic signed [DW-1:0] s_do_re, s_do_im;
  logic d_di_rdy, d_do_sop, d_do_win, d_do_vld;
  logic signed [DW-1:0] d_do_re, d_do_im;

  always #5 clk = ~clk;

  // Main instance, default parameters
  scds_gen u_a (
    .clk(clk), .rst(rst), .mode(mode), .di_re(di_re), .di_im(di_im), .di_sop(di_sop),
    .di_vld(di_vld), .di_rdy(a_di_rdy), .do_re(a_do_re), .do_im(a_do_im),
    .do_sop(a_do_sop), .do_win(a_do_win), .do_vld(a_do_vld), .do_rdy(do_rdy));

  // Narrow window instance fed with the same stream
  scds_gen #(.WIN_START(2), .WIN_END(4)) u_w (
    .clk(clk), .rst(rst), .mode(mode), .di_re(di_re), .di_im(di_im), .di_sop(di_sop),
    .di_vld(di_vld), .di_rdy(w_di_rdy), .do_re(w_do_re), .do_im(w_do_im),
    .do_sop(w_do_sop), .do_win(w_do_win), .do_vld(w_do_vld), .do_rdy(do_rdy));

  // Scrambler feeding a descrambler
  scds_gen u_s (
    .clk(clk), .rst(rst), .mode(1'b1), .di_re(di_re), .di_im(di_im), .di_sop(di_sop),
    .di_vld(di_vld), .di_rdy(s_di_rdy), .do_re(s_do_re), .do_im(s_do_im),
    .do_sop(s_do_sop), .do_win(s_do_win), .do_vld(s_do_vld), .do_rdy(d_di_rdy));

  scds_gen u_d (
    .clk(clk), .rst(rst), .mode(1'b0), .di_re(s_do_re), .di_im(s_do_im), .di_sop(s_do_sop),
    .di_vld(s_do_vld), .di_rdy(d_di_rdy), .do_re(d_do_re), .do_im(d_do_im),
    .do_sop(d_do_sop), .do_win(d_do_win), .do_vld(d_do_vld), .do_rdy(do_rdy));

  int n_cmp = 0;
  int n_bad = 0;

  logic signed [DW-1:0] src_re[$], src_im[$];
  logic                 src_sop[$], src_mode[$];
  bit                   rdy_pat[$];
  logic signed [DW-1:0] ca_re[$], ca_im[$], cw_re[$], cw_im[$], cd_re[$], cd_im[$];
  logic                 ca_sop[$], ca_win[$], cw_win[$];
  int                   hold_err, stall_cnt;

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; di_vld = 1'b0; di_sop = 1'b0; do_rdy = 1'b1; mode = 1'b0;
    di_re = '0; di_im = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_src;
    src_re.delete(); src_im.delete(); src_sop.delete(); src_mode.delete(); rdy_pat.delete();
  endtask

  task automatic push(input int re, input int im, input bit sop, input bit md);
    src_re.push_back(DW'(re)); src_im.push_back(DW'(im));
    src_sop.push_back(sop);    src_mode.push_back(md);
  endtask

  // Streams src_* into the shared inputs, capturing every handshaken output
  task automatic run(input bit need_d);
    int n, sent, cyc;
    bit hold_prev;
    logic signed [DW-1:0] h_re, h_im;
    logic h_sop, h_win;
    n = src_re.size(); sent = 0; cyc = 0; hold_prev = 1'b0;
    h_re = '0; h_im = '0; h_sop = 1'b0; h_win = 1'b0;
    ca_re.delete(); ca_im.delete(); ca_sop.delete(); ca_win.delete();
    cw_re.delete(); cw_im.delete(); cw_win.delete(); cd_re.delete(); cd_im.delete();
    hold_err = 0; stall_cnt = 0;
    while ((ca_re.size() < n || (need_d && cd_re.size() < n)) && cyc < 2000) begin
      @(negedge clk);
      do_rdy = (cyc < rdy_pat.size()) ? rdy_pat[cyc] : 1'b1;
      if (sent < n) begin
        di_vld = 1'b1; di_re = src_re[sent]; di_im = src_im[sent];
        di_sop = src_sop[sent]; mode = src_mode[sent];
      end else begin
        di_vld = 1'b0; di_sop = 1'b0;
      end
      #1;
      if (hold_prev && (a_do_re !== h_re || a_do_im !== h_im || a_do_sop !== h_sop ||
                        a_do_win !== h_win || a_do_vld !== 1'b1)) hold_err++;
      hold_prev = a_do_vld && !do_rdy;
      if (hold_prev) stall_cnt++;
      h_re = a_do_re; h_im = a_do_im; h_sop = a_do_sop; h_win = a_do_win;
      if (a_do_vld && do_rdy) begin
        ca_re.push_back(a_do_re); ca_im.push_back(a_do_im);
        ca_sop.push_back(a_do_sop); ca_win.push_back(a_do_win);
      end
      if (w_do_vld && do_rdy) begin
        cw_re.push_back(w_do_re); cw_im.push_back(w_do_im); cw_win.push_back(w_do_win);
      end
      if (d_do_vld && do_rdy) begin
        cd_re.push_back(d_do_re); cd_im.push_back(d_do_im);
      end
      if (di_vld && a_di_rdy) sent++;
      cyc++;
    end
    @(negedge clk);
    di_vld = 1'b0; di_sop = 1'b0; do_rdy = 1'b1;
    if (cyc >= 2000) begin
      n_cmp++; n_bad++;
      $display("FAIL run_timeout: captured %0d samples, required %0d", ca_re.size(), n);
    end
  endtask

  task automatic check_size(input string name, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_bad++; $display("FAIL %s_count: got %0d required %0d", name, got, want);
    end
  endtask

  // Expected descramble output for the (100,-50) frame at a given index
  task automatic check_frame(input string name, input bit scr, input int first, input int last);
    int er, ei;
    for (int i = first; i <= last && i < ca_re.size(); i++) begin
      er = 100; ei = -50;
      if (i == 16 || i == 21) begin er = scr ? -50 : 50; ei = scr ? -100 : 100; end
      if (i == 22 || i == 23) begin er = -100; ei = 50; end
      n_cmp++;
      if (ca_re[i] !== DW'(er) || ca_im[i] !== DW'(ei)) begin
        n_bad++;
        $display("FAIL %s_data idx %0d: got (%0d,%0d) required (%0d,%0d)", name, i, ca_re[i], ca_im[i], er, ei);
      end
      n_cmp++;
      if (ca_win[i] !== (i >= 16) || ca_sop[i] !== (i == 0)) begin
        n_bad++;
        $display("FAIL %s_flags idx %0d: got win=%0b sop=%0b required win=%0b sop=%0b", name, i, ca_win[i], ca_sop[i], i >= 16, i == 0);
      end
    end
  endtask

  task automatic test_reset;
    do_reset;
    #1;
    n_cmp++;
    if (a_do_re !== 0 || a_do_im !== 0 || a_do_sop !== 0 || a_do_win !== 0 || a_do_vld !== 0) begin
      n_bad++; $display("FAIL reset_outputs: got re=%0d im=%0d sop=%0b win=%0b vld=%0b required all 0", a_do_re, a_do_im, a_do_sop, a_do_win, a_do_vld);
    end
    n_cmp++;
    if (a_di_rdy !== 1'b1) begin n_bad++; $display("FAIL reset_di_rdy: got %0b required 1", a_di_rdy); end
    n_cmp++;
    if (u_a.u_lfsr.s_q !== 13'h1FFF) begin n_bad++; $display("FAIL reset_lfsr: got %h required 1fff", u_a.u_lfsr.s_q); end
    // Load one sample, stall it, then reset asynchronously mid-cycle
    @(negedge clk);
    di_vld = 1'b1; di_sop = 1'b1; di_re = 12'sd100; di_im = 12'sd7; do_rdy = 1'b0;
    @(negedge clk);
    di_vld = 1'b0; di_sop = 1'b0;
    #1;
    n_cmp++;
    if (a_do_vld !== 1'b1 || a_do_re !== 12'sd100) begin
      n_bad++; $display("FAIL inflight_loaded: got vld=%0b re=%0d required vld=1 re=100", a_do_vld, a_do_re);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (a_do_vld !== 1'b0 || a_do_re !== 0 || a_do_im !== 0 || a_do_sop !== 0) begin
      n_bad++; $display("FAIL async_reset_drop: got vld=%0b re=%0d im=%0d sop=%0b required all 0", a_do_vld, a_do_re, a_do_im, a_do_sop);
    end
    @(negedge clk);
    rst = 1'b0; do_rdy = 1'b1;
  endtask

  task automatic test_descramble;
    do_reset; clear_src;
    for (int i = 0; i < 24; i++) push(100, -50, i == 0, 1'b0);
    run(1'b0);
    check_size("desc", ca_re.size(), 24);
    check_frame("desc", 1'b0, 0, 23);
  endtask

  task automatic test_scramble;
    do_reset; clear_src;
    // Mode is high only on the sop; the mid-frame drop must be ignored
    for (int i = 0; i < 24; i++) push(100, -50, i == 0, i == 0);
    run(1'b0);
    check_size("scr", ca_re.size(), 24);
    check_frame("scr", 1'b1, 0, 23);
  endtask

  task automatic test_window;
    int er, ei, ix;
    do_reset; clear_src;
    for (int i = 0; i < 16; i++) push(100, -50, (i % 8) == 0, 1'b0);
    run(1'b0);
    check_size("win", cw_re.size(), 16);
    for (int i = 0; i < 16 && i < cw_re.size(); i++) begin
      ix = i % 8;
      er = (ix == 2) ? 50 : 100;
      ei = (ix == 2) ? 100 : -50;
      n_cmp++;
      if (cw_re[i] !== DW'(er) || cw_im[i] !== DW'(ei) || cw_win[i] !== (ix >= 2 && ix <= 4)) begin
        n_bad++;
        $display("FAIL win_sample pos %0d: got (%0d,%0d) win=%0b required (%0d,%0d) win=%0b", i, cw_re[i], cw_im[i], cw_win[i], er, ei, ix >= 2 && ix <= 4);
      end
    end
  endtask

  task automatic test_backpressure;
    do_reset; clear_src;
    for (int i = 0; i < 24; i++) push(100, -50, i == 0, 1'b0);
    for (int c = 0; c < 30; c++) rdy_pat.push_back(!(c == 18 || c == 19 || c == 22));
    run(1'b0);
    check_size("bp", ca_re.size(), 24);
    check_frame("bp", 1'b0, 0, 23);
    check_size("bp_stalls", stall_cnt, 3);
    check_size("bp_hold_violations", hold_err, 0);
  endtask

  task automatic test_saturation;
    do_reset; clear_src;
    for (int i = 0; i < 23; i++) push(-2048, -2048, i == 0, 1'b0);
    run(1'b0);
    check_size("sat", ca_re.size(), 23);
    if (ca_re.size() == 23) begin
      n_cmp++;
      if (ca_re[5] !== -12'sd2048 || ca_im[5] !== -12'sd2048) begin
        n_bad++; $display("FAIL sat_pass: got (%0d,%0d) required (-2048,-2048)", ca_re[5], ca_im[5]);
      end
      n_cmp++;
      if (ca_re[21] !== 12'sd2047 || ca_im[21] !== -12'sd2048) begin
        n_bad++; $display("FAIL sat_pj: got (%0d,%0d) required (2047,-2048)", ca_re[21], ca_im[21]);
      end
      n_cmp++;
      if (ca_re[22] !== 12'sd2047 || ca_im[22] !== 12'sd2047) begin
        n_bad++; $display("FAIL sat_neg: got (%0d,%0d) required (2047,2047)", ca_re[22], ca_im[22]);
      end
    end
  endtask

  task automatic test_mid_sop;
    do_reset; clear_src;
    for (int i = 0; i < 48; i++) push(100, -50, i == 0 || i == 30, 1'b0);
    run(1'b0);
    check_size("msop", ca_re.size(), 48);
    if (ca_re.size() == 48) begin
      n_cmp++;
      if (ca_re[16] !== 12'sd50 || ca_im[16] !== 12'sd100 || ca_win[29] !== 1'b1) begin
        n_bad++; $display("FAIL msop_first_frame: got (%0d,%0d) win29=%0b required (50,100) win29=1", ca_re[16], ca_im[16], ca_win[29]);
      end
      n_cmp++;
      if (ca_sop[30] !== 1'b1 || ca_win[30] !== 1'b0 || ca_re[30] !== 12'sd100) begin
        n_bad++; $display("FAIL msop_restart: got sop=%0b win=%0b re=%0d required sop=1 win=0 re=100", ca_sop[30], ca_win[30], ca_re[30]);
      end
      n_cmp++;
      if (ca_win[31] !== 1'b0 || ca_re[31] !== 12'sd100 || ca_im[31] !== -12'sd50) begin
        n_bad++; $display("FAIL msop_idx1: got win=%0b (%0d,%0d) required win=0 (100,-50)", ca_win[31], ca_re[31], ca_im[31]);
      end
      n_cmp++;
      if (ca_win[46] !== 1'b1 || ca_re[46] !== 12'sd50 || ca_im[46] !== 12'sd100) begin
        n_bad++; $display("FAIL msop_idx16: got win=%0b (%0d,%0d) required win=1 (50,100)", ca_win[46], ca_re[46], ca_im[46]);
      end
      n_cmp++;
      if (ca_win[47] !== 1'b1 || ca_re[47] !== 12'sd100 || ca_im[47] !== -12'sd50) begin
        n_bad++; $display("FAIL msop_idx17: got win=%0b (%0d,%0d) required win=1 (100,-50)", ca_win[47], ca_re[47], ca_im[47]);
      end
    end
  endtask

  task automatic test_round_trip;
    do_reset; clear_src;
    for (int i = 0; i < 495; i++)
      push(int'($urandom_range(4094)) - 2047, int'($urandom_range(4094)) - 2047, i == 0, 1'b0);
    run(1'b1);
    check_size("rt", cd_re.size(), 495);
    for (int i = 0; i < 495 && i < cd_re.size(); i++) begin
      n_cmp++;
      if (cd_re[i] !== src_re[i] || cd_im[i] !== src_im[i]) begin
        n_bad++; $display("FAIL rt_sample %0d: got (%0d,%0d) required (%0d,%0d)", i, cd_re[i], cd_im[i], src_re[i], src_im[i]);
      end
    end
    if (ca_win.size() == 495) begin
      n_cmp++;
      if (ca_win[15] !== 1'b0 || ca_win[16] !== 1'b1 || ca_win[494] !== 1'b1) begin
        n_bad++; $display("FAIL rt_window_edges: got %0b%0b%0b required 011", ca_win[15], ca_win[16], ca_win[494]);
      end
    end
  endtask

  task automatic test_idx_sat;
    do_reset; clear_src;
    for (int i = 0; i < 1045; i++) push(100, -50, i == 0, 1'b0);
    run(1'b0);
    check_size("isat", ca_re.size(), 1045);
    if (ca_re.size() == 1045) begin
      n_cmp++;
      if (ca_win[1023] !== 1'b0 || ca_win[1040] !== 1'b0 || ca_re[1040] !== 12'sd100 || ca_im[1040] !== -12'sd50) begin
        n_bad++; $display("FAIL isat_no_wrap: got win1023=%0b win1040=%0b (%0d,%0d) required 0 0 (100,-50)", ca_win[1023], ca_win[1040], ca_re[1040], ca_im[1040]);
      end
    end
  endtask

  initial begin
    mode = 1'b0; di_sop = 1'b0; di_vld = 1'b0; do_rdy = 1'b1; di_re = '0; di_im = '0;
    test_reset;
    test_descramble;
    test_scramble;
    test_window;
    test_backpressure;
    test_saturation;
    test_mid_sop;
    test_round_trip;
    test_idx_sat;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/scds_gen.md
Name: scds_gen

Overview:
- Parametrised signal-constellation scrambler/descrambler for the OFDM signal segment.
- Applies a per-sample quarter-turn rotation (0, ×j, ×−1, ×−j), selected by a 13-bit dual-output LFSR, to samples whose in-frame index lies inside a configurable window.
- Sits between the FFT/equaliser output and the demapper (descramble mode), or before the IFFT (scramble mode).
- Adds valid/ready backpressure, explicit start-of-frame, a run-time mode select and saturating negation.

Parameters:
- DW, 12, sample width per component (two's complement).
- IW, 10, frame index counter width.
- WIN_START, 16, first scrambled sample index (inclusive).
- WIN_END, 494, last scrambled sample index (inclusive).
- SEED, 13'h1FFF, LFSR load value, bit 0 = MSB-side s[0].

Ports:
- clk  in  1  working clock
- rst  in  1  reset, asynchronous, active-high
- mode  in  1  0 = descramble, 1 = scramble; sampled on accepted di_sop
- di_re  in  DW  input real, signed
- di_im  in  DW  input imag, signed
- di_sop  in  1  marks frame sample index 0
- di_vld  in  1  input valid
- di_rdy  out  1  input ready
- do_re  out  DW  output real, signed
- do_im  out  DW  output imag, signed
- do_sop  out  1  sop aligned to do_*
- do_win  out  1  output sample was inside the window
- do_vld  out  1  output valid
- do_rdy  in  1  downstream ready

Behaviour:
- Reset: do_re = do_im = 0; do_sop = do_win = do_vld = 0; idx = 0; LFSR = SEED; latched mode = 0.
- Handshake and latency:
  - Accept when di_vld && di_rdy; di_rdy = !do_vld || do_rdy (combinational).
  - Latency is 1 cycle, with one register stage.
  - While do_vld && !do_rdy, all do_* hold stable.
- Index:
  - An accepted sample with di_sop gets idx 0, and the counter becomes 1.
  - Otherwise each accepted sample gets the current idx and the counter increments.
  - The counter saturates at 2^IW−1 and never wraps.
  - Before the first sop after reset, the idx counter runs from 0.
- Mode:
  - Latched on an accepted sop, and applies to the sop sample itself.
  - A mode change mid-frame is ignored.
- Window: in_win = WIN_START ≤ idx ≤ WIN_END for the accepted sample.
- LFSR, state s[0:12]:
  - fb1 = s7^s10^s11^s12; fb2 = s6^s9^s10^s11.
  - Advance: s ← {fb2, fb1, s[0:10]}.
  - Advances only on an accepted in_win sample, after that sample uses the current state.
  - Reloads SEED on an accepted sop, or on any accepted out-of-window sample.
  - Stalls never advance it.
- Rotation for in_win samples, selected by sel = {s0, s1}:
  - Descramble:
    - 00: (re, im)
    - 10: (im, −re)
    - 01: (−re, −im)
    - 11: (−im, re)
  - Scramble swaps the 10 and 11 rows, giving the inverse rotation.
  - Out-of-window samples pass unchanged.
- Arithmetic: negation saturates, so −(−2^(DW−1)) = 2^(DW−1)−1. No other width growth.
- Simultaneous events:
  - sop mid-frame restarts idx and reseeds, aborting the old frame with no flush.
  - sop on a stalled cycle takes effect only when accepted.
- rst mid-frame: all state returns to reset values immediately, and in-flight output is dropped.

Decomposition:
- Package scds_pkg:
  - SEED default and tap positions.
  - Rotation encoding constants ROT_ID, ROT_NJ, ROT_NEG, ROT_PJ.
  - A saturating-negate function.
- Sub-module scds_lfsr:
  - 13-bit dual-output LFSR.
  - Ports: clk, rst, load, adv, sel[1:0].
  - load has priority over adv.

Test Plan:
- Reset then idle: all outputs 0, di_rdy = 1, LFSR = 1FFF.
- Descramble, default parameters, frame of 20 samples all (re=100, im=−50), do_rdy = 1:
  - idx 0–15 pass unchanged.
  - idx 16 (sel 11) → (50, 100).
  - idx 17–19 (sel 00) → (100, −50).
  - do_win first set at idx 16.
- Window end with WIN_START=2, WIN_END=4:
  - idx 5 passes unchanged.
  - LFSR reseeds, so the next frame's idx 2 again gives sel 11.
- Backpressure: toggle do_rdy 1,0,0,1 mid-window.
  - No sample is lost or duplicated.
  - LFSR sequence is identical to the no-stall run.
  - do_* are stable during stall cycles.
- Saturation: in-window sample (−2048, −2048) with sel 01 → (2047, 2047).
- Round trip: scramble-mode instance feeding a descramble-mode instance, 495-sample random frame.
  - Output equals input bit-exactly, excluding saturated codes.
- sop asserted at idx 30 mid-frame: the next sample gets idx 1, and the LFSR restarts from SEED at idx 16.
